// File: rtl/hazard_pkg.sv
// Shared types and default configuration for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF  = 5;
  localparam int MDU_LATENCY_DEF = 4;
  localparam int CNT_W_DEF       = 32;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mdu_state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Bypass select for one E-stage source operand; M stage wins over W,
// and register x0 is never forwarded.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] i_rsE,
  input  logic [REG_ADDR_W-1:0] i_rdM,
  input  logic [REG_ADDR_W-1:0] i_rdW,
  input  logic                  i_regWriteM,
  input  logic                  i_regWriteW,
  output fwd_sel_t              o_fwd
);

  // Pick the youngest in-flight producer of the operand, if any.
  always_comb begin
    o_fwd = FWD_RF;
    if (i_regWriteM && (i_rdM == i_rsE) && (i_rsE != '0)) begin
      o_fwd = FWD_M;
    end else if (i_regWriteW && (i_rdW == i_rsE) && (i_rsE != '0)) begin
      o_fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch
// flush, memory-wait stall, optional multicycle MUL/DIV sequencer and a
// saturating stall-cycle counter.
// Optional MDU sequencer is compiled in when HAZARD_MDU_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MDU_LATENCY = MDU_LATENCY_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  ResultSrcE0,
  input  logic                  PCSrcE,
  input  logic                  MduStartE,
  input  logic                  MemReadyM,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  FlushW,
  output logic                  MduBusy,
  output logic                  MduDone,
  output logic [CNT_W-1:0]      StallCnt
);

  fwd_sel_t         w_fwdA;
  fwd_sel_t         w_fwdB;
  logic             w_lwStall;
  logic             w_mduBusy;
  logic             w_mduDone;
  logic [CNT_W-1:0] r_stallCnt;

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwdA (
    .i_rsE       (Rs1E),
    .i_rdM       (RdM),
    .i_rdW       (RdW),
    .i_regWriteM (RegWriteM),
    .i_regWriteW (RegWriteW),
    .o_fwd       (w_fwdA)
  );

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwdB (
    .i_rsE       (Rs2E),
    .i_rdM       (RdM),
    .i_rdW       (RdW),
    .i_regWriteM (RegWriteM),
    .i_regWriteW (RegWriteW),
    .o_fwd       (w_fwdB)
  );

  assign ForwardAE = reset ? 2'b00 : w_fwdA;
  assign ForwardBE = reset ? 2'b00 : w_fwdB;

  assign w_lwStall = ResultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));

`ifdef HAZARD_MDU_EN
  localparam int MDU_CNT_W = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;
  localparam logic [MDU_CNT_W-1:0] MDU_LOAD = MDU_CNT_W'(MDU_LATENCY - 2);

  mdu_state_t           r_state;
  mdu_state_t           w_stateNext;
  logic [MDU_CNT_W-1:0] r_cnt;
  logic [MDU_CNT_W-1:0] w_cntNext;

  // MDU state and remaining-cycle counter; reset aborts any running op.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Sequencer: a memory wait freezes the count so the op keeps its slot.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      IDLE: begin
        if (MduStartE && MemReadyM) begin
          w_stateNext = BUSY;
          w_cntNext   = MDU_LOAD;
        end
      end
      BUSY: begin
        if (MemReadyM) begin
          if (r_cnt == '0) begin
            w_stateNext = DONE;
          end else begin
            w_cntNext = r_cnt - MDU_CNT_W'(1);
          end
        end
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign w_mduBusy = (r_state == BUSY);
  assign w_mduDone = (r_state == DONE);
`else
  logic w_unused;
  assign w_unused  = MduStartE | (MDU_LATENCY < 2);
  assign w_mduBusy = 1'b0;
  assign w_mduDone = 1'b0;
`endif

  assign MduBusy = !reset && w_mduBusy;
  assign MduDone = !reset && w_mduDone;

  // Stall/flush resolution, highest priority first; branch flush is only
  // reachable when E is not held, so a stalled branch waits in E.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FlushW = 1'b1;
    end else if (!MemReadyM) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (w_mduBusy) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (w_lwStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Count fetch-stall cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stallCnt <= '0;
    end else if (StallF && (r_stallCnt != {CNT_W{1'b1}})) begin
      r_stallCnt <= r_stallCnt + CNT_W'(1);
    end
  end

  assign StallCnt = r_stallCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl. MDU sequences are exercised
// when HAZARD_MDU_EN is defined; otherwise MduStartE is checked to be inert.
module tb_hazard_ctrl;

  typedef struct {
    logic       reset;
    logic [4:0] rs1D;
    logic [4:0] rs2D;
    logic [4:0] rs1E;
    logic [4:0] rs2E;
    logic [4:0] rdE;
    logic [4:0] rdM;
    logic [4:0] rdW;
    logic       regWriteM;
    logic       regWriteW;
    logic       resultSrcE0;
    logic       pcSrcE;
    logic       mduStartE;
    logic       memReadyM;
    logic [1:0] expFwdA;
    logic [1:0] expFwdB;
    logic [3:0] expStall;
    logic [3:0] expFlush;
    logic       expBusy;
    logic       expDone;
    logic [3:0] expCnt;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MduStartE, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushM, FlushW;
  logic       MduBusy, MduDone;
  logic [3:0] StallCnt;

  int testsRun  = 0;
  int failCount = 0;

  vec_t tbl[$];

  hazard_ctrl #(
    .REG_ADDR_W  (5),
    .MDU_LATENCY (4),
    .CNT_W       (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .RdM         (RdM),
    .RdW         (RdW),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .ResultSrcE0 (ResultSrcE0),
    .PCSrcE      (PCSrcE),
    .MduStartE   (MduStartE),
    .MemReadyM   (MemReadyM),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushM      (FlushM),
    .FlushW      (FlushW),
    .MduBusy     (MduBusy),
    .MduDone     (MduDone),
    .StallCnt    (StallCnt)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quiet cycle: memory ready, nothing hazardous, expect no stall/flush.
  function automatic vec_t base(input logic [3:0] cnt);
    vec_t v;
    v = '{default: '0};
    v.memReadyM = 1'b1;
    v.expCnt    = cnt;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset       = v.reset;
    Rs1D        = v.rs1D;
    Rs2D        = v.rs2D;
    Rs1E        = v.rs1E;
    Rs2E        = v.rs2E;
    RdE         = v.rdE;
    RdM         = v.rdM;
    RdW         = v.rdW;
    RegWriteM   = v.regWriteM;
    RegWriteW   = v.regWriteW;
    ResultSrcE0 = v.resultSrcE0;
    PCSrcE      = v.pcSrcE;
    MduStartE   = v.mduStartE;
    MemReadyM   = v.memReadyM;
    #2;
  endtask

  task automatic checkOne(input string tag, input string what,
                          input logic [3:0] got, input logic [3:0] want);
    testsRun++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s %s: got %b want %b", tag, what, got, want);
    end
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    checkOne(tag, "fwdA", {2'b00, ForwardAE}, {2'b00, v.expFwdA});
    checkOne(tag, "fwdB", {2'b00, ForwardBE}, {2'b00, v.expFwdB});
    checkOne(tag, "stallFDEM", {StallF, StallD, StallE, StallM}, v.expStall);
    checkOne(tag, "flushDEMW", {FlushD, FlushE, FlushM, FlushW}, v.expFlush);
    checkOne(tag, "busyDone", {2'b00, MduBusy, MduDone}, {2'b00, v.expBusy, v.expDone});
    checkOne(tag, "stallCnt", StallCnt, v.expCnt);
  endtask

  task automatic runStep(input vec_t v, input string tag);
    applyStimulus(v);
    checkOutput(v, tag);
  endtask

  // Build the vector table, run it, then the multi-cycle sequences.
  initial begin
    vec_t v;

    v = base(4'd0);
    v.reset = 1'b1;
    applyStimulus(v);
    applyStimulus(v);

    // reset overrides forwarding, flushes everything
    v = base(0); v.reset = 1; v.rs1E = 5; v.rdM = 5; v.regWriteM = 1;
    v.expFlush = 4'b1111; tbl.push_back(v);
    // M forward on A
    v = base(0); v.rs1E = 5; v.rdM = 5; v.regWriteM = 1;
    v.expFwdA = 2'b10; tbl.push_back(v);
    // M beats W
    v = base(0); v.rs1E = 5; v.rdM = 5; v.regWriteM = 1; v.rdW = 5; v.regWriteW = 1;
    v.expFwdA = 2'b10; tbl.push_back(v);
    // x0 never forwarded
    v = base(0); v.rs1E = 0; v.rdM = 0; v.regWriteM = 1; tbl.push_back(v);
    // W forward on B, A has no producer
    v = base(0); v.rs1E = 3; v.rs2E = 9; v.rdM = 4; v.regWriteM = 1; v.rdW = 9; v.regWriteW = 1;
    v.expFwdB = 2'b01; tbl.push_back(v);
    // M match but not writing -> W
    v = base(0); v.rs2E = 6; v.rdM = 6; v.rdW = 6; v.regWriteW = 1;
    v.expFwdB = 2'b01; tbl.push_back(v);
    // x0 from W not forwarded
    v = base(0); v.rdW = 0; v.regWriteW = 1; tbl.push_back(v);
    // load-use on Rs2D
    v = base(0); v.resultSrcE0 = 1; v.rdE = 7; v.rs2D = 7;
    v.expStall = 4'b1100; v.expFlush = 4'b0100; tbl.push_back(v);
    v = base(1); tbl.push_back(v);
    // load into x0 never stalls
    v = base(1); v.resultSrcE0 = 1; v.rdE = 0; tbl.push_back(v);
    // load-use on Rs1D
    v = base(1); v.resultSrcE0 = 1; v.rdE = 3; v.rs1D = 3;
    v.expStall = 4'b1100; v.expFlush = 4'b0100; tbl.push_back(v);
    // same registers but not a load
    v = base(2); v.rdE = 3; v.rs1D = 3; tbl.push_back(v);
    // taken branch
    v = base(2); v.pcSrcE = 1; v.expFlush = 4'b1100; tbl.push_back(v);
    // memory wait
    v = base(2); v.memReadyM = 0; v.expStall = 4'b1111; v.expFlush = 4'b0001; tbl.push_back(v);
    // memory wait beats load-use
    v = base(3); v.memReadyM = 0; v.resultSrcE0 = 1; v.rdE = 7; v.rs1D = 7;
    v.expStall = 4'b1111; v.expFlush = 4'b0001; tbl.push_back(v);
    // branch held while E stalled
    v = base(4); v.memReadyM = 0; v.pcSrcE = 1;
    v.expStall = 4'b1111; v.expFlush = 4'b0001; tbl.push_back(v);
    // branch released
    v = base(5); v.pcSrcE = 1; v.expFlush = 4'b1100; tbl.push_back(v);
    // reset with a load-use present
    v = base(5); v.reset = 1; v.resultSrcE0 = 1; v.rdE = 7; v.rs1D = 7;
    v.expFlush = 4'b1111; tbl.push_back(v);
    v = base(0); tbl.push_back(v);

    for (int i = 0; i < tbl.size(); i++) begin
      runStep(tbl[i], $sformatf("vec%0d", i));
    end

`ifdef HAZARD_MDU_EN
    // plain MDU op, MduStartE held while the op sits in E
    v = base(0); v.mduStartE = 1; runStep(v, "mdu0");
    for (int k = 0; k < 3; k++) begin
      v = base(4'(k)); v.mduStartE = 1; v.expBusy = 1;
      v.expStall = 4'b1110; v.expFlush = 4'b0010;
      runStep(v, $sformatf("mduBusy%0d", k));
    end
    v = base(3); v.mduStartE = 1; v.expDone = 1; runStep(v, "mduDone");
    v = base(3); runStep(v, "mduIdle");

    // memory wait during BUSY delays completion by two cycles
    v = base(3); v.mduStartE = 1; runStep(v, "mw0");
    v = base(3); v.mduStartE = 1; v.expBusy = 1;
    v.expStall = 4'b1110; v.expFlush = 4'b0010; runStep(v, "mw1");
    for (int k = 0; k < 2; k++) begin
      v = base(4'(4 + k)); v.mduStartE = 1; v.memReadyM = 0; v.expBusy = 1;
      v.expStall = 4'b1111; v.expFlush = 4'b0001;
      runStep(v, $sformatf("mwWait%0d", k));
    end
    for (int k = 0; k < 2; k++) begin
      v = base(4'(6 + k)); v.mduStartE = 1; v.expBusy = 1;
      v.expStall = 4'b1110; v.expFlush = 4'b0010;
      runStep(v, $sformatf("mwBusy%0d", k));
    end
    v = base(8); v.mduStartE = 1; v.expDone = 1; runStep(v, "mwDone");
    v = base(8); runStep(v, "mwIdle");

    // reset aborts BUSY
    v = base(8); v.mduStartE = 1; runStep(v, "rb0");
    v = base(8); v.mduStartE = 1; v.expBusy = 1;
    v.expStall = 4'b1110; v.expFlush = 4'b0010; runStep(v, "rb1");
    v = base(9); v.mduStartE = 1; v.reset = 1; v.expFlush = 4'b1111; runStep(v, "rbReset");
    v = base(0); runStep(v, "rbAfter0");
    v = base(0); runStep(v, "rbAfter1");
`else
    // MduStartE has no effect without the MDU
    for (int k = 0; k < 4; k++) begin
      v = base(0); v.mduStartE = 1;
      runStep(v, $sformatf("noMdu%0d", k));
    end
`endif

    // saturation of the stall counter
    v = base(0); v.reset = 1; v.expFlush = 4'b1111; runStep(v, "satReset");
    for (int k = 0; k < 18; k++) begin
      v = base((k > 15) ? 4'd15 : 4'(k)); v.memReadyM = 0;
      v.expStall = 4'b1111; v.expFlush = 4'b0001;
      runStep(v, $sformatf("sat%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-index width.
REQ-002 SHALL have parameter MDU_LATENCY, default 4, number of cycles a multicycle MUL/DIV op occupies E, with a legal range of 2..32.
REQ-003 SHALL have parameter CNT_W, default 32, width of the stall-cycle counter.
REQ-004 SHALL use one clock and a synchronous, active-high reset. The ports are:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous active-high reset
  Rs1D, Rs2D  in  REG_ADDR_W  source registers in D
  Rs1E, Rs2E  in  REG_ADDR_W  source registers in E
  RdE, RdM, RdW  in  REG_ADDR_W  destination registers per stage
  RegWriteM, RegWriteW  in  1  register write enable in M and W
  ResultSrcE0  in  1  instruction in E is a load
  PCSrcE  in  1  taken branch or jump resolved in E
  MduStartE  in  1  instruction in E is a multicycle MDU op
  MemReadyM  in  1  data memory has completed the access in M
  ForwardAE, ForwardBE  out  2  operand A/B bypass select
  StallF, StallD, StallE, StallM  out  1  hold the stage register
  FlushD, FlushE, FlushM, FlushW  out  1  bubble the stage register
  MduBusy  out  1  MDU sequence in progress
  MduDone  out  1  one-cycle pulse: MDU result valid in E
  StallCnt  out  CNT_W  count of cycles with StallF=1

Function
REQ-005 Forwarding SHALL select Forward=10 (from M) when RegWriteM is high, RdM==RsE and RsE!=0. Otherwise it SHALL select 01 (from W) when RegWriteW is high, RdW==RsE and RsE!=0. Otherwise it SHALL select 00. M SHALL win over W. Forwarding SHALL be combinational with no latency.
REQ-006 Load-use hazard: lwStall = ResultSrcE0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE). On lwStall the block SHALL assert StallF, StallD and FlushE.
REQ-007 Branch: PCSrcE SHALL assert FlushD and FlushE, but only in a cycle where StallE=0. A branch whose E stage is stalled SHALL be deferred until that stage releases.
REQ-008 Memory wait: MemReadyM=0 SHALL assert StallF, StallD, StallE and StallM, SHALL assert FlushW, and SHALL suppress every other flush.
REQ-009 Priority SHALL be, highest first: reset, memory wait, MDU busy, load-use, branch.
REQ-010 MDU FSM states SHALL be IDLE, BUSY and DONE, with a down-counter of width clog2(MDU_LATENCY).
REQ-011 IDLE to BUSY SHALL occur when MduStartE=1 and MemReadyM=1. On that transition the counter SHALL load MDU_LATENCY-2.
REQ-012 In BUSY the block SHALL assert MduBusy, StallF, StallD and StallE, and SHALL assert FlushM. The counter SHALL decrement only while MemReadyM=1. When the counter reaches 0 the FSM SHALL move to DONE.
REQ-013 In DONE the block SHALL assert MduDone for exactly one cycle with no stalls from the MDU. The FSM SHALL then return to IDLE. In that return cycle MduStartE SHALL be ignored so the same op is not restarted.
REQ-014 MduStartE SHALL be ignored in BUSY and DONE.
REQ-015 StallCnt SHALL increment on each cycle in which StallF=1 and SHALL saturate at all-ones without wrapping.
REQ-016 PCSrcE together with ResultSrcE0 or MduStartE comes from one E instruction and is mutually exclusive. Behaviour in that case is unspecified.

Reset
REQ-017 While reset=1 the block SHALL drive every Stall* output to 0, drive FlushD, FlushE, FlushM and FlushW to 1, drive ForwardAE and ForwardBE to 00, and drive MduBusy and MduDone to 0.
REQ-018 On a clk edge with reset=1 the FSM SHALL go to IDLE and the counter and StallCnt SHALL clear to 0. This SHALL also abort an MDU sequence that is in BUSY.

Configuration
REQ-019 The macro HAZARD_MDU_EN, when defined, SHALL compile in the FSM and counter as described in REQ-010..REQ-014.
REQ-020 When HAZARD_MDU_EN is undefined, the MduStartE port SHALL remain but be ignored, MduBusy and MduDone SHALL be tied to 0, and no MDU state SHALL exist.

Structure
REQ-021 Package hazard_pkg SHALL hold:
  fwd_sel_t enum: FWD_RF=00, FWD_W=01, FWD_M=10
  mdu_state_t enum: IDLE, BUSY, DONE
  default parameter constants
REQ-022 Sub-module fwd_sel SHALL implement one operand's forwarding select and SHALL be instantiated twice, once for A and once for B.

Verification
REQ-023 Forwarding and x0:
  Rs1E=5, RdM=5, RegWriteM=1 -> ForwardAE=10
  Same stimulus with RdW=5, RegWriteW=1 also present -> ForwardAE still 10
  Rs1E=0, RdM=0 -> ForwardAE=00
REQ-024 Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for 1 cycle and StallCnt +1. With RdE=0 -> no stall.
REQ-025 MDU with MDU_LATENCY=4: MduStartE pulse -> MduBusy=1 for 3 cycles, then MduDone=1 for 1 cycle, and StallCnt increases by 3.
REQ-026 MemReadyM=0 for 2 cycles during MDU BUSY -> Stall F/D/E/M=1 and FlushW=1, the counter frozen, and MduDone delayed by exactly 2 cycles.
REQ-027 Reset asserted mid-BUSY -> on the next edge state is IDLE, MduBusy=0 and StallCnt=0. Force StallCnt to all-ones then stall -> StallCnt holds all-ones.
